// File: rtl/ov7670_gen_pkg.sv
// Shared types and constants for the OV7670-compatible stream generator.
package ov7670_gen_pkg;

  typedef enum logic [1:0] {
    RAMP  = 2'd0,
    BARS  = 2'd1,
    CHECK = 2'd2,
    CONST = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [15:0] BAR_RGB565 [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // RGB565 words go out MSB first; any extra bytes of a wider pixel are zero.
  function automatic logic [7:0] rgb565_byte(input logic [15:0] word, input logic [31:0] bidx);
    if (bidx == 32'd0)      return word[15:8];
    else if (bidx == 32'd1) return word[7:0];
    else                    return 8'h00;
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Camera-side parallel bus: PCLK, VSYNC, HREF and the 8-bit data byte.
interface ov7670_stream_gen_if;
  logic       pclk_o;
  logic       vsync_o;
  logic       href_o;
  logic [7:0] d_o;

  modport master (output pclk_o, vsync_o, href_o, d_o);
  modport slave  (input  pclk_o, vsync_o, href_o, d_o);
endinterface

// File: rtl/ov7670_gen_timing.sv
// PCLK enable divider, byte/line position counters and VSYNC/HREF/frame_done decode.
module ov7670_gen_timing #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 784,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 510,
  parameter int V_SYNC_LINES = 3,
  parameter int V_FRONT      = 20,
  parameter int BPP          = 2,
  parameter int CLK_DIV      = 2,
  parameter int BYTE_W       = $clog2(BPP * H_TOTAL),
  parameter int LINE_W       = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stream,
  output logic              tick,
  output logic              pclk,
  output logic              vsync,
  output logic              href,
  output logic              frame_last,
  output logic              frame_done,
  output logic [BYTE_W-1:0] nxt_byte,
  output logic [LINE_W-1:0] nxt_line,
  output logic              nxt_href,
  output logic [LINE_W-1:0] line_cnt
);

  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int BYTES_LINE = BPP * H_TOTAL;
  localparam int BYTES_ACT  = BPP * H_ACTIVE;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [BYTE_W-1:0] byte_cnt;
  logic              byte_last;
  logic              line_last;

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;

  // Divider is free-running; pclk tracks the upper half of the byte period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pclk    <= (div_nxt >= DIV_W'(CLK_DIV / 2));
    end
  end

  // Next position is what the registered outputs show after the coming tick.
  always_comb begin
    byte_last = (byte_cnt == BYTE_W'(BYTES_LINE - 1));
    line_last = (line_cnt == LINE_W'(V_TOTAL - 1));
    nxt_byte  = '0;
    nxt_line  = '0;
    if (run) begin
      nxt_byte = byte_last ? '0 : byte_cnt + 1'b1;
      nxt_line = line_cnt;
      if (byte_last) nxt_line = line_last ? '0 : line_cnt + 1'b1;
    end
    nxt_href = (32'(nxt_line) >= V_FRONT) &&
               (32'(nxt_line) <  V_FRONT + V_ACTIVE) &&
               (32'(nxt_byte) <  BYTES_ACT);
  end

  assign frame_last = run && byte_last && line_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      vsync    <= 1'b0;
      href     <= 1'b0;
    end else if (tick) begin
      byte_cnt <= nxt_byte;
      line_cnt <= nxt_line;
      vsync    <= stream && (32'(nxt_line) < V_SYNC_LINES);
      href     <= stream && nxt_href;
    end
  end

  // Pulse spans the final clk of the frame's last byte period, i.e. the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= frame_last && (div_cnt == DIV_W'(CLK_DIV - 2));
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-compatible camera stream generator: run/idle FSM plus test-pattern mux.
// Build option OV_GEN_FRAME_TAG_EN: byte 0 of each frame's first active pixel carries a frame counter.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 784,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 510,
  parameter int V_SYNC_LINES = 3,
  parameter int V_FRONT      = 20,
  parameter int BPP          = 2,
  parameter int CLK_DIV      = 2,
  parameter int RAMP_STEP    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  mode_e                     mode,
  input  logic [15:0]               const_px,
  ov7670_stream_gen_if.master       cam,
  output logic                      frame_done,
  output logic [9:0]                line_idx,
  output logic                      busy
);

  localparam int BYTE_W = $clog2(BPP * H_TOTAL);
  localparam int LINE_W = $clog2(V_TOTAL);
  localparam int BAR_PX = H_ACTIVE / 8;

  state_e            state;
  logic              busy_q;
  mode_e             mode_q;
  logic [15:0]       const_q;
  logic [7:0]        ramp_acc;
  logic [7:0]        d_q;
  logic [7:0]        d_nxt;
  logic [7:0]        pat;

  logic              tick;
  logic              pclk;
  logic              vsync;
  logic              href;
  logic              frame_last;
  logic              run;
  logic              stream;
  logic              frame_start;
  logic [BYTE_W-1:0] nxt_byte;
  logic [LINE_W-1:0] nxt_line;
  logic              nxt_href;
  logic [LINE_W-1:0] line_cnt;

  logic [31:0]       px;
  logic [31:0]       bidx;
  logic [31:0]       aline;
  logic [31:0]       bar_i;
  logic [2:0]        bar;

  ov7670_gen_timing #(
    .H_ACTIVE     (H_ACTIVE),
    .H_TOTAL      (H_TOTAL),
    .V_ACTIVE     (V_ACTIVE),
    .V_TOTAL      (V_TOTAL),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_FRONT      (V_FRONT),
    .BPP          (BPP),
    .CLK_DIV      (CLK_DIV),
    .BYTE_W       (BYTE_W),
    .LINE_W       (LINE_W)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .stream     (stream),
    .tick       (tick),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .frame_last (frame_last),
    .frame_done (frame_done),
    .nxt_byte   (nxt_byte),
    .nxt_line   (nxt_line),
    .nxt_href   (nxt_href),
    .line_cnt   (line_cnt)
  );

  // A frame in flight always completes; en only decides whether another follows.
  assign run         = (state == RUN);
  assign stream      = (state == IDLE) ? en : !(frame_last && !en);
  assign frame_start = ((state == IDLE) && en) || (frame_last && en);

`ifdef OV_GEN_FRAME_TAG_EN
  logic [7:0] frame_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_tag <= '0;
    else if (frame_done) frame_tag <= frame_tag + 1'b1;
  end
`endif

  always_comb begin
    px    = 32'(nxt_byte) / BPP;
    bidx  = 32'(nxt_byte) % BPP;
    aline = 32'(nxt_line) - V_FRONT;
    bar_i = px / BAR_PX;
    bar   = (bar_i > 32'd7) ? 3'd7 : bar_i[2:0];
    pat   = 8'h00;
    case (mode_q)
      RAMP:    pat = ramp_acc;
      BARS:    pat = rgb565_byte(BAR_RGB565[bar], bidx);
      CHECK:   pat = ((((px >> 3) ^ (aline >> 3)) & 32'd1) != 32'd0) ? 8'hFF : 8'h00;
      CONST:   pat = rgb565_byte(const_q, bidx);
      default: pat = 8'h00;
    endcase
`ifdef OV_GEN_FRAME_TAG_EN
    if ((px == 32'd0) && (aline == 32'd0) && (bidx == 32'd0)) pat = frame_tag;
`endif
    d_nxt = (stream && nxt_href) ? pat : 8'h00;
  end

  // Pattern settings are captured only at frame start so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      mode_q   <= RAMP;
      const_q  <= '0;
      ramp_acc <= '0;
      d_q      <= '0;
    end else if (tick) begin
      d_q <= d_nxt;
      if (frame_start) begin
        mode_q   <= mode;
        const_q  <= const_px;
        ramp_acc <= '0;
      end else if (stream && nxt_href && (bidx == 32'(BPP - 1))) begin
        ramp_acc <= ramp_acc + 8'(RAMP_STEP);
      end
      case (state)
        IDLE: begin
          if (en) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (frame_last && !en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cam.pclk_o  = pclk;
  assign cam.vsync_o = vsync;
  assign cam.href_o  = href;
  assign cam.d_o     = d_q;
  assign busy        = busy_q;
  assign line_idx    = 10'(line_cnt);

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Randomised self-checking bench for ov7670_stream_gen on a reduced frame geometry.
module tb_ov7670_stream_gen;
  import ov7670_gen_pkg::*;

  localparam int HA   = 8;
  localparam int HT   = 12;
  localparam int VA   = 4;
  localparam int VT   = 8;
  localparam int VS   = 1;
  localparam int VF   = 2;
  localparam int BPP  = 2;
  localparam int CD   = 2;
  localparam int STEP = 16;
  localparam int BPL  = BPP * HT;
`ifdef OV_GEN_FRAME_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  mode_e       mode;
  logic [15:0] const_px;
  logic        frame_done;
  logic [9:0]  line_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int fno      = 0;
  int rise_gap = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  ov7670_stream_gen_if cam ();

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .V_SYNC_LINES(VS), .V_FRONT(VF), .BPP(BPP), .CLK_DIV(CD), .RAMP_STEP(STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .const_px   (const_px),
    .cam        (cam.master),
    .frame_done (frame_done),
    .line_idx   (line_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected byte from the pattern definitions, position-based (no accumulator).
  function automatic logic [7:0] model_byte(input mode_e m, input logic [15:0] c,
                                            input int line, input int b, input int fn);
    int px, bi, al;
    logic [2:0]  bsel;
    logic [15:0] rgb;
    if (line < VF || line >= VF + VA || b >= BPP * HA) return 8'h00;
    px = b / BPP;
    bi = b % BPP;
    al = line - VF;
    if (TAG_EN && px == 0 && al == 0 && bi == 0) return 8'(fn % 256);
    case (m)
      RAMP:  return 8'(((al * HA + px) * STEP) % 256);
      BARS: begin
        bsel = 3'(px / (HA / 8));
        rgb  = bars[bsel];
        return (bi == 0) ? rgb[15:8] : ((bi == 1) ? rgb[7:0] : 8'h00);
      end
      CHECK: return ((((px >> 3) ^ (al >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return (bi == 0) ? c[15:8] : ((bi == 1) ? c[7:0] : 8'h00);
    endcase
  endfunction

  function automatic logic [31:0] pack_obs();
    return {10'd0, cam.vsync_o, cam.href_o, frame_done, busy, line_idx, cam.d_o};
  endfunction

  // Returns on the negedge that first sees pclk high after being low.
  task automatic wait_rise();
    logic prev;
    bit   got;
    int   n;
    prev = cam.pclk_o;
    got  = 1'b0;
    n    = 0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      if (cam.pclk_o && !prev) got = 1'b1;
      prev = cam.pclk_o;
    end
    rise_gap = n;
    if (!got) check_eq("pclk_timeout", 32'd0, 32'd1);
  endtask

  task automatic sync_start(input int max_rises);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_rises && !found; i++) begin
      wait_rise();
      if (cam.vsync_o) found = 1'b1;
    end
    check_eq("start_vsync", 32'(found), 32'd1);
  endtask

  task automatic check_frame(input mode_e m, input logic [15:0] c, input bit first_wait,
                             input int set_line, input mode_e nm, input logic [15:0] nc,
                             input bit drop_en, input int stop_line);
    logic [31:0] exp;
    bit vs, hr, fd;
    for (int line = 0; line < VT; line++) begin
      for (int b = 0; b < BPL; b++) begin
        if (first_wait || line != 0 || b != 0) wait_rise();
        vs  = (line < VS);
        hr  = (line >= VF) && (line < VF + VA) && (b < BPP * HA);
        fd  = (line == VT - 1) && (b == BPL - 1);
        exp = {10'd0, vs, hr, fd, 1'b1, 10'(line), model_byte(m, c, line, b, fno)};
        check_eq("stream", pack_obs(), exp);
        if (line == stop_line) return;
        if (line == set_line && b == 0) begin
          mode     = nm;
          const_px = nc;
        end
        if (drop_en && line == 1 && b == 0) en = 1'b0;
      end
    end
    fno++;
  endtask

  initial begin
    mode_e       cm, nm;
    logic [15:0] cc, nc;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = RAMP;
    const_px = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("reset_obs", pack_obs(), 32'd0);
    check_eq("reset_pclk", 32'(cam.pclk_o), 32'd0);
    rst_n = 1'b1;

    repeat (4) wait_rise();
    check_eq("idle_obs", pack_obs(), 32'd0);
    check_eq("pclk_period", 32'(rise_gap), 32'(CD));

    en = 1'b1;
    sync_start(4);
    check_frame(RAMP, 16'h0000, 1'b0, 3, CHECK, 16'h1234, 1'b0, -1);

    cm = CHECK;
    cc = 16'h1234;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       begin nm = BARS;  nc = 16'($urandom); end
        1:       begin nm = CONST; nc = 16'hABCD;      end
        default: begin nm = mode_e'($urandom_range(0, 3)); nc = 16'($urandom); end
      endcase
      check_frame(cm, cc, 1'b1, int'($urandom_range(0, VT - 1)), nm, nc, (k == 6), -1);
      cm = nm;
      cc = nc;
    end
    repeat (3) wait_rise();
    check_eq("idle_after_drop", pack_obs(), 32'd0);

    mode     = RAMP;
    const_px = 16'h0000;
    en       = 1'b1;
    sync_start(4);
    check_frame(RAMP, 16'h0000, 1'b0, -1, RAMP, 16'h0000, 1'b0, 4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_reset_obs", pack_obs(), 32'd0);
    check_eq("async_reset_pclk", 32'(cam.pclk_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fno   = 0;

    sync_start(2);
    nc = 16'($urandom);
    check_frame(RAMP, 16'h0000, 1'b0, 2, CONST, nc, 1'b0, -1);
    check_frame(CONST, nc, 1'b1, -1, RAMP, 16'h0000, 1'b1, -1);
    repeat (3) wait_rise();
    check_eq("idle_final", pack_obs(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
